// File: rtl/prod_div8_pkg.sv
// Shared types and widths for the product divider: FSM states and operand sizes.
package prod_div8_pkg;

  localparam int OP_W   = 8;
  localparam int PROD_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/prod_div8_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor when it fits, and report the quotient bit.
module div_step
  import prod_div8_pkg::*;
(
  input  logic [OP_W:0]   rem_in,
  input  logic            bit_in,
  input  logic [OP_W-1:0] divisor,
  output logic [OP_W:0]   rem_out,
  output logic            q_bit
);

  logic [OP_W+1:0] shifted_s;
  logic [OP_W:0]   diff_s;

  assign shifted_s = {rem_in, bit_in};
  // When the divisor fits, the difference is below the divisor and so fits the working width.
  assign diff_s    = shifted_s[OP_W:0] - {1'b0, divisor};
  assign q_bit     = (shifted_s >= {2'b00, divisor});
  assign rem_out   = q_bit ? diff_s : shifted_s[OP_W:0];

endmodule

// File: rtl/prod_div8.sv
// Recovers the 8-bit multiplicand from a 16-bit product and the known multiplier
// by restoring division, STEPS_PER_CYCLE steps per clock, with valid/ready handshakes.
module prod_div8
  import prod_div8_pkg::*;
#(
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] prod,
  input  logic [OP_W-1:0]   b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OP_W-1:0]   quot,
  output logic [OP_W-1:0]   rem,
  output logic              ovf,
  output logic              dz
);

  localparam int         N_CYC    = OP_W / STEPS_PER_CYCLE;
  localparam logic [3:0] LAST_CNT = 4'(N_CYC - 1);

  state_t          state_r;
  logic [OP_W:0]   rem_r;
  logic [OP_W-1:0] q_r;
  logic [OP_W-1:0] b_r;
  logic [3:0]      cnt_r;
  logic [OP_W:0]   rem_fin_s;
  logic [OP_W-1:0] q_fin_s;

  // The quotient register doubles as the dividend shifter: its MSB feeds each step.
  for (genvar i = 0; i < STEPS_PER_CYCLE; i++) begin : g_step
    logic [OP_W:0]   rem_in_s;
    logic [OP_W:0]   rem_out_s;
    logic [OP_W-1:0] q_in_s;
    logic [OP_W-1:0] q_out_s;
    logic            qbit_s;

    if (i == 0) begin : g_first
      assign rem_in_s = rem_r;
      assign q_in_s   = q_r;
    end else begin : g_next
      assign rem_in_s = g_step[i-1].rem_out_s;
      assign q_in_s   = g_step[i-1].q_out_s;
    end

    div_step u_step (
      .rem_in  (rem_in_s),
      .bit_in  (q_in_s[OP_W-1]),
      .divisor (b_r),
      .rem_out (rem_out_s),
      .q_bit   (qbit_s)
    );

    assign q_out_s = {q_in_s[OP_W-2:0], qbit_s};
  end

  assign rem_fin_s = g_step[STEPS_PER_CYCLE-1].rem_out_s;
  assign q_fin_s   = g_step[STEPS_PER_CYCLE-1].q_out_s;

  // Handshake FSM, datapath registers and registered result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      quot      <= 8'h00;
      rem       <= 8'h00;
      ovf       <= 1'b0;
      dz        <= 1'b0;
      rem_r     <= 9'h000;
      q_r       <= 8'h00;
      b_r       <= 8'h00;
      cnt_r     <= 4'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready) begin
            b_r      <= b;
            cnt_r    <= 4'd0;
            in_ready <= 1'b0;
            if (b == 8'h00) begin
              state_r   <= DONE;
              out_valid <= 1'b1;
              dz        <= 1'b1;
              ovf       <= 1'b0;
              quot      <= 8'hFF;
              rem       <= prod[7:0];
            end else if (prod[15:8] >= b) begin
              state_r   <= DONE;
              out_valid <= 1'b1;
              dz        <= 1'b0;
              ovf       <= 1'b1;
              quot      <= 8'hFF;
              rem       <= 8'h00;
            end else begin
              state_r <= RUN;
              rem_r   <= {1'b0, prod[15:8]};
              q_r     <= prod[7:0];
            end
          end
        end
        RUN: begin
          rem_r <= rem_fin_s;
          q_r   <= q_fin_s;
          cnt_r <= cnt_r + 4'd1;
          if (cnt_r == LAST_CNT) begin
            state_r   <= DONE;
            out_valid <= 1'b1;
            quot      <= q_fin_s;
            rem       <= rem_fin_s[OP_W-1:0];
            ovf       <= 1'b0;
            dz        <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r   <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            cnt_r     <= 4'd0;
          end
        end
        default: begin
          state_r   <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          cnt_r     <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prod_div8.sv
// Bench for prod_div8: directed vector table, handshake/reset sequences and
// random operands against an arithmetic reference, on 1- and 4-step instances.
module tb_prod_div8;

  logic clk = 1'b0;
  logic rst;
  logic [1:0]       in_valid;
  logic [1:0]       out_ready;
  logic [1:0][15:0] prod;
  logic [1:0][7:0]  b;
  wire  [1:0]       in_ready;
  wire  [1:0]       out_valid;
  wire  [1:0]       ovf;
  wire  [1:0]       dz;
  wire  [1:0][7:0]  quot;
  wire  [1:0][7:0]  rem;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] p;
    logic [7:0]  d;
    logic [7:0]  q;
    logic [7:0]  r;
    logic        o;
    logic        z;
  } vec_t;

  vec_t tbl [8];

  always #5 clk = ~clk;

  prod_div8 #(.STEPS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .prod(prod[0]), .b(b[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .quot(quot[0]), .rem(rem[0]), .ovf(ovf[0]), .dz(dz[0])
  );

  prod_div8 #(.STEPS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .prod(prod[1]), .b(b[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .quot(quot[1]), .rem(rem[1]), .ovf(ovf[1]), .dz(dz[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer division with the zero and overflow rules on top.
  function automatic void model(input logic [15:0] p, input logic [7:0] d,
                                output logic [7:0] q, output logic [7:0] r,
                                output logic o, output logic z);
    int qi;
    int ri;
    if (d == 8'd0) begin
      z = 1'b1; o = 1'b0; q = 8'hFF; r = p[7:0];
    end else begin
      qi = int'(p) / int'(d);
      ri = int'(p) % int'(d);
      z  = 1'b0;
      if (qi > 255) begin
        o = 1'b1; q = 8'hFF; r = 8'h00;
      end else begin
        o = 1'b0; q = qi[7:0]; r = ri[7:0];
      end
    end
  endfunction

  task automatic txn(input int sel, input logic [15:0] p, input logic [7:0] d,
                     input logic [7:0] eq, input logic [7:0] er, input logic eo,
                     input logic ez, input int hold, input string tag);
    int lat;
    int exp_lat;
    int waited;
    logic [7:0] q0;
    logic [7:0] r0;
    logic o0;
    logic z0;
    exp_lat = (eo || ez) ? 1 : (8 / ((sel == 0) ? 1 : 4)) + 1;
    @(negedge clk);
    waited = 0;
    while (!in_ready[sel] && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, "_ready"}, {31'd0, in_ready[sel]}, 32'd1);
    in_valid[sel] = 1'b1;
    prod[sel] = p;
    b[sel] = d;
    @(posedge clk);
    #1;
    // Keep in_valid high with junk operands: neither may disturb the running job.
    prod[sel] = 16'($urandom);
    b[sel] = 8'($urandom);
    lat = 1;
    @(negedge clk);
    while (!out_valid[sel] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    in_valid[sel] = 1'b0;
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_quot"}, {24'd0, quot[sel]}, {24'd0, eq});
    chk({tag, "_rem"}, {24'd0, rem[sel]}, {24'd0, er});
    chk({tag, "_ovf_dz"}, {30'd0, ovf[sel], dz[sel]}, {30'd0, eo, ez});
    q0 = quot[sel]; r0 = rem[sel]; o0 = ovf[sel]; z0 = dz[sel];
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold"}, {12'd0, quot[sel], rem[sel], ovf[sel], dz[sel], out_valid[sel], in_ready[sel]},
          {12'd0, q0, r0, o0, z0, 1'b1, 1'b0});
    end
    out_ready[sel] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[sel] = 1'b0;
    @(negedge clk);
    chk({tag, "_release"}, {30'd0, in_ready[sel], out_valid[sel]}, 32'd2);
  endtask

  initial begin
    logic [7:0]  eq;
    logic [7:0]  er;
    logic        eo;
    logic        ez;
    logic [15:0] rp;
    logic [7:0]  rd;
    int          seen;

    rst = 1'b1;
    in_valid = 2'b00;
    out_ready = 2'b00;
    prod = '0;
    b = '0;

    tbl[0] = '{16'h3B19, 8'd123, 8'd123, 8'd0,   1'b0, 1'b0};
    tbl[1] = '{16'd1000, 8'd7,   8'd142, 8'd6,   1'b0, 1'b0};
    tbl[2] = '{16'h1234, 8'd0,   8'hFF,  8'h34,  1'b0, 1'b1};
    tbl[3] = '{16'h0800, 8'd8,   8'hFF,  8'h00,  1'b1, 1'b0};
    tbl[4] = '{16'd255,  8'd1,   8'd255, 8'd0,   1'b0, 1'b0};
    tbl[5] = '{16'hFFFF, 8'd255, 8'hFF,  8'h00,  1'b1, 1'b0};
    tbl[6] = '{16'hFEFF, 8'd255, 8'd255, 8'd254, 1'b0, 1'b0};
    tbl[7] = '{16'h00FE, 8'd255, 8'd0,   8'd254, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("reset_ctl%0d", s), {30'd0, in_ready[s], out_valid[s]}, 32'd2);
      chk($sformatf("reset_data%0d", s), {14'd0, quot[s], rem[s], ovf[s], dz[s]}, 32'd0);
    end
    rst = 1'b0;

    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 8; i++) begin
        txn(s, tbl[i].p, tbl[i].d, tbl[i].q, tbl[i].r, tbl[i].o, tbl[i].z, 0,
            $sformatf("vec%0d_s%0d", i, s));
      end
    end

    txn(0, 16'd1000, 8'd7, 8'd142, 8'd6, 1'b0, 1'b0, 5, "hold5");

    // Reset in the third RUN cycle aborts the job without a late result.
    @(negedge clk);
    in_valid[0] = 1'b1;
    prod[0] = 16'd1000;
    b[0] = 8'd7;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_now", {30'd0, in_ready[0], out_valid[0]}, 32'd2);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid[0]) seen++;
    end
    chk("abort_no_result", seen, 0);
    txn(0, 16'd255, 8'd1, 8'd255, 8'd0, 1'b0, 1'b0, 0, "after_abort");

    for (int i = 0; i < 24; i++) begin
      rd = 8'($urandom);
      if (i % 5 == 0) rd = 8'd0;
      if (i % 4 == 1 || rd == 8'd0) rp = 16'($urandom);
      else rp = {8'($urandom_range(0, int'(rd) - 1)), 8'($urandom)};
      model(rp, rd, eq, er, eo, ez);
      txn(i % 2, rp, rd, eq, er, eo, ez, int'($urandom_range(0, 2)),
          $sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prod_div8.md
PROD_DIV8 -- requirements
Module: prod_div8

Interface
REQ-001 The block SHALL have parameter STEPS_PER_CYCLE, default 1, giving restoring-division steps per clock; legal values are 1, 2, 4 and 8.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the operand pair is valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept an operand pair.
REQ-006 The block SHALL have port prod, input, 16 bits: unsigned dividend, typically an 8x8 multiplier product.
REQ-007 The block SHALL have port b, input, 8 bits: unsigned divisor, the known multiplier operand.
REQ-008 The block SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-010 The block SHALL have port quot, output, 8 bits: the recovered operand a, equal to prod / b.
REQ-011 The block SHALL have port rem, output, 8 bits: prod mod b.
REQ-012 The block SHALL have port ovf, output, 1 bit: the true quotient exceeds 255.
REQ-013 The block SHALL have port dz, output, 1 bit: b was zero.

Function
REQ-014 The FSM SHALL have states IDLE, RUN and DONE; in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-015 When in_valid and in_ready are both 1 at a clock edge, the block SHALL capture prod and b; a later change on those inputs SHALL have no effect.
REQ-016 At acceptance, if b==0, the next state SHALL be DONE with dz=1, ovf=0, quot=8'hFF and rem=prod[7:0].
REQ-017 At acceptance, if b!=0 and prod[15:8]>=b, the next state SHALL be DONE with ovf=1, dz=0, quot=8'hFF and rem=8'h00; the dz check SHALL have priority over this check.
REQ-018 Otherwise the next state SHALL be RUN, with the partial remainder set to prod[15:8] (9-bit working width) and the quotient shift register set to prod[7:0].
REQ-019 Each step SHALL shift {remainder, quotient MSB} left by one; if the shifted remainder is >= b, the step SHALL subtract b and shift in quotient bit 1, otherwise it SHALL shift in 0.
REQ-020 RUN SHALL last exactly 8/STEPS_PER_CYCLE cycles, counted by a step counter, and SHALL then go to DONE with quot = the shift register, rem = the remainder[7:0], and ovf=dz=0.
REQ-021 Latency from the acceptance edge to out_valid=1 SHALL be 8/STEPS_PER_CYCLE+1 cycles for normal operands and 1 cycle for the dz and ovf cases.
REQ-022 In DONE, quot, rem, ovf and dz SHALL be registered and held stable until out_valid and out_ready are both 1 at a clock edge; the state SHALL then return to IDLE.
REQ-023 The block SHALL NOT overlap transactions: in_valid is ignored outside IDLE.
REQ-024 quot, rem, ovf and dz SHALL be don't-care while out_valid=0, but SHALL NOT change while out_valid=1.

Reset
REQ-025 While rst=1, the block SHALL be in state IDLE with in_ready=1, out_valid=0, quot=0, rem=0, ovf=0, dz=0, and the step counter at 0.
REQ-026 Reset asserted in RUN or DONE SHALL abort the transaction; no result SHALL be emitted for it after rst is released.

Structure
REQ-027 A shared package SHALL hold the state enum (IDLE, RUN, DONE), the operand width constant 8, and the product width constant 16.
REQ-028 One combinational sub-module, div_step, SHALL implement a single restoring step (inputs: remainder, incoming bit, divisor; outputs: new remainder, quotient bit); the top SHALL instantiate it STEPS_PER_CYCLE times in a chain.

Verification
REQ-029 The bench SHALL cover: S=1, prod=16'h3B19 (15129), b=123 -> quot=123, rem=0, ovf=0, dz=0, out_valid 9 cycles after accept.
REQ-030 The bench SHALL cover: prod=1000, b=7 -> quot=142, rem=6; repeated with STEPS_PER_CYCLE=4 -> the same result 3 cycles after accept.
REQ-031 The bench SHALL cover: prod=16'h1234, b=0 -> dz=1, ovf=0, quot=8'hFF, rem=8'h34, out_valid 1 cycle after accept.
REQ-032 The bench SHALL cover: prod=16'h0800, b=8 -> ovf=1, dz=0, quot=8'hFF, rem=0, out_valid 1 cycle after accept.
REQ-033 The bench SHALL cover: out_ready held low 5 cycles in DONE -> outputs stable and in_ready=0 throughout; out_ready=1 -> in_ready=1 on the following cycle.
REQ-034 The bench SHALL cover: rst pulsed on the 3rd RUN cycle -> out_valid=0 and in_ready=1 immediately; the next transaction (prod=255, b=1 -> quot=255, rem=0) completes normally.
